pi_step_pipe: RTL and testbench
===============================

PI_STEP_PIPE -- requirements
Module: pi_step_pipe

Interface
REQ-001 Parameter LANE_W, default 64, lane width in bits; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 Parameter NUM_STAGES, default 1, number of register stages; legal values 1 to 4.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, the input state is valid.
REQ-006 Port in_ready, output, 1, the block accepts the input state this cycle.
REQ-007 Port in_mode, input, 2, transform select: 00 forward pi, 01 inverse pi, 10 identity, 11 reserved.
REQ-008 Port state_array_in, input, 5x5xLANE_W packed [x][y][z], input state A.
REQ-009 Port out_valid, output, 1, the output state is valid.
REQ-010 Port out_ready, input, 1, the downstream accepts the output state.
REQ-011 Port state_array_out, output, 5x5xLANE_W packed [x][y][z], transformed state.
REQ-012 Port occupancy, output, clog2(NUM_STAGES+1), number of valid stages held.
REQ-013 Port mode_err, output, 1, one-cycle pulse when an accepted transfer carries mode 11.

Function
REQ-014 A transfer in or out SHALL occur only on a cycle where the valid and ready signals are both high.
REQ-015 Forward mode SHALL produce out[x][y] = A[(x+3y) mod 5][x] for every z.
REQ-016 Inverse mode SHALL produce out[x][y] = A[y][(2x+3y) mod 5] for every z.
REQ-017 Identity mode SHALL produce out = A.
REQ-018 Mode 11 SHALL be treated as identity and SHALL assert mode_err in the cycle after acceptance.
REQ-019 The transform SHALL be applied combinationally before stage 1.
REQ-020 Stage 1 SHALL register the transformed state, and each later stage SHALL carry the data forward unchanged.
REQ-021 With out_ready held high, the latency from input accept to out_valid SHALL be exactly NUM_STAGES cycles.
REQ-022 With out_ready held high, throughput SHALL be one state per cycle.
REQ-023 Stage k SHALL advance when it is empty or when stage k+1 advances; the last stage advances when out_ready is high.
REQ-024 in_ready SHALL equal the stage-1 advance condition and SHALL be combinational from out_ready; no skid buffer is used.
REQ-025 When stalled, a stage SHALL hold its data and valid bit unchanged.
REQ-026 state_array_out SHALL hold stable while out_valid is high and out_ready is low.
REQ-027 The pipeline SHALL be full when occupancy equals NUM_STAGES.
REQ-028 When the pipeline is full and out_ready is low, in_ready SHALL be 0.
REQ-029 When the pipeline is full and out_ready is high, a simultaneous input accept and output transfer SHALL occur, and occupancy SHALL stay unchanged.
REQ-030 occupancy SHALL increment on an accept without an output transfer, decrement on an output transfer without an accept, and otherwise hold.
REQ-031 occupancy SHALL never exceed NUM_STAGES and SHALL never wrap below 0.
REQ-032 The mode SHALL be sampled per transfer, so back-to-back transfers with different modes are each transformed correctly.

Reset
REQ-033 While rst is high at a clock edge, all stage valid bits, occupancy and mode_err SHALL clear to 0 at that edge.
REQ-034 state_array_out SHALL read all-zero after reset; data registers SHALL be cleared on reset.
REQ-035 A reset mid-operation SHALL discard all in-flight states with no output transfer in that cycle.
REQ-036 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-037 ROW_SIZE=5, COL_SIZE=5, the mode enum (PI_FWD, PI_INV, PI_ID, PI_RSVD) and a parametrised state typedef SHALL reside in keccak_pkg.
REQ-038 The lane index map SHALL be a single combinational sub-module pi_map, with LANE_W and mode inputs, instantiated once ahead of stage 1.

Verification
REQ-039 Scenario: LANE_W=64, NUM_STAGES=1, out_ready=1, forward mode, lane A[x][y]=64'h(10x+y) -> after 1 cycle out[1][0] = A[1][1] = 0x11 and out[0][1] = A[3][0] = 0x30.
REQ-040 Scenario: forward then inverse round-trip, LANE_W=8, random A -> result equals A, with zero mismatches over 1000 vectors.
REQ-041 Scenario: NUM_STAGES=3, continuous in_valid, out_ready low for 5 cycles -> occupancy=3, in_ready=0, output stable; release -> 3 states out in order, with no loss or duplicate.
REQ-042 Scenario: full pipeline with out_ready=1 and in_valid=1 -> simultaneous transfer, occupancy holds at NUM_STAGES.
REQ-043 Scenario: mode=11 accepted -> mode_err pulses for 1 cycle and the output equals the input.
REQ-044 Scenario: rst asserted with occupancy=2 -> next cycle out_valid=0, occupancy=0, in_ready=1.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak state geometry and the pi-step transform modes.
package keccak_pkg;

  localparam int ROW_SIZE   = 5;
  localparam int COL_SIZE   = 5;
  localparam int MAX_LANE_W = 64;

  // Transform select carried with every transfer.
  typedef enum logic [1:0] {
    PI_FWD  = 2'b00,
    PI_INV  = 2'b01,
    PI_ID   = 2'b10,
    PI_RSVD = 2'b11
  } pi_mode_e;

  // State at the widest lane; blocks narrow the z dimension to their LANE_W.
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][MAX_LANE_W-1:0] state_max_t;

endpackage

// File: rtl/pi_map.sv
// Combinational pi lane permutation: forward, inverse, or pass-through.
// Lanes move as whole words, so the map is pure wiring plus a 3-way mux.
module pi_map
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [1:0]                                    i_mode,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] i_state,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] o_state
);

  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] w_fwd;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] w_inv;

  // Fixed lane routing for both directions; indices are elaboration constants.
  for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_x
    for (genvar gy = 0; gy < COL_SIZE; gy++) begin : g_y
      assign w_fwd[gx][gy] = i_state[(gx + 3*gy) % ROW_SIZE][gx];
      assign w_inv[gx][gy] = i_state[gy][(2*gx + 3*gy) % COL_SIZE];
    end
  end

  // Select the routing; the reserved code falls through to identity.
  always_comb begin
    o_state = i_state;
    case (pi_mode_e'(i_mode))
      PI_FWD:  o_state = w_fwd;
      PI_INV:  o_state = w_inv;
      default: o_state = i_state;
    endcase
  end

endmodule

// File: rtl/pi_step_pipe.sv
// Pi-step transform followed by a NUM_STAGES-deep valid/ready register pipe.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high. Stage k loads when it is empty or stage k+1 loads; the last stage
// loads when it is empty or out_ready is high. in_ready is the stage-1 load
// condition, so it is combinational from out_ready (no skid buffer). While
// rst is high both in_ready and out_valid are forced low so nothing moves.
module pi_step_pipe
  import keccak_pkg::*;
#(
  parameter int LANE_W     = 64,
  parameter int NUM_STAGES = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [1:0]                                    in_mode,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] state_array_in,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] state_array_out,
  output logic [$clog2(NUM_STAGES+1)-1:0]               occupancy,
  output logic                                          mode_err
);

  localparam int OCC_W = $clog2(NUM_STAGES + 1);
  localparam int LAST  = NUM_STAGES - 1;

  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_W-1:0] state_t;

  logic [NUM_STAGES-1:0] r_valid;
  state_t                r_data [NUM_STAGES];
  logic [OCC_W-1:0]      r_occ;
  logic                  r_mode_err;

  logic [NUM_STAGES-1:0] w_adv;
  state_t                w_mapped;
  logic                  w_accept;
  logic                  w_out_xfer;

  // Transform sits ahead of stage 1 so every later stage is a plain copy.
  pi_map #(
    .LANE_W (LANE_W)
  ) u_pi_map (
    .i_mode  (in_mode),
    .i_state (state_array_in),
    .o_state (w_mapped)
  );

  // Advance chain from the output back: a stage moves if any stage from it
  // to the end is empty, or the consumer takes the last one.
  always_comb begin
    logic l_run;
    l_run = out_ready;
    w_adv = '0;
    for (int k = LAST; k >= 0; k--) begin
      l_run    = l_run || !r_valid[k];
      w_adv[k] = l_run;
    end
  end

  assign in_ready        = w_adv[0] && !rst;
  assign out_valid       = r_valid[LAST] && !rst;
  assign state_array_out = r_data[LAST];
  assign occupancy       = r_occ;
  assign mode_err        = r_mode_err;
  assign w_accept        = in_valid && in_ready;
  assign w_out_xfer      = out_valid && out_ready;

  // Stage registers: data only reloads when a valid word arrives, so a
  // drained pipe keeps showing its last word and never picks up garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < NUM_STAGES; k++) r_data[k] <= '0;
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) r_data[0] <= w_mapped;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  // Occupancy tracks accepts minus output transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_out_xfer})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // One-cycle flag for an accepted transfer with the reserved mode code.
  always_ff @(posedge clk) begin
    if (rst) r_mode_err <= 1'b0;
    else     r_mode_err <= w_accept && (pi_mode_e'(in_mode) == PI_RSVD);
  end

endmodule

// File: tb/tb_pi_step_pipe.sv
// Bench for pi_step_pipe: a 64-bit single-stage instance and an 8-bit
// three-stage instance, driven by directed scenarios and random traffic,
// checked against a lane-array reference model and expected queues.
module tb_pi_step_pipe;

  localparam int SW = 1600;
  localparam int NA = 1;
  localparam int NB = 3;

  typedef logic [63:0] lanes_t [5][5];

  logic clk;
  logic rst;

  logic                  a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_mode_err;
  logic [1:0]            a_in_mode;
  logic [4:0][4:0][63:0] a_din, a_dout;
  logic [0:0]            a_occ;

  logic                  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_mode_err;
  logic [1:0]            b_in_mode;
  logic [4:0][4:0][7:0]  b_din, b_dout;
  logic [1:0]            b_occ;

  pi_step_pipe #(.LANE_W(64), .NUM_STAGES(NA)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .state_array_in(a_din), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .state_array_out(a_dout), .occupancy(a_occ),
    .mode_err(a_mode_err)
  );

  pi_step_pipe #(.LANE_W(8), .NUM_STAGES(NB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .state_array_in(b_din), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .state_array_out(b_dout), .occupancy(b_occ),
    .mode_err(b_mode_err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;
  int occ_m [2];
  logic [SW-1:0] exp_q_a [$];
  logic [SW-1:0] exp_q_b [$];
  logic [SW-1:0] cap_q [$];
  logic [SW-1:0] orig_q [$];

  // ---------------- reference model ----------------
  // Forward gathers out[x][y] from A[(x+3y)%5][x]; inverse scatters each
  // lane back to where forward fetched it from, so inverse(forward(A)) = A.
  function automatic lanes_t ref_pi(input lanes_t a, input logic [1:0] mode);
    lanes_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = a[x][y];
    if (mode == 2'b00) begin
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          r[x][y] = a[(x + 3*y) % 5][x];
    end else if (mode == 2'b01) begin
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          r[(x + 3*y) % 5][x] = a[x][y];
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] pack64(input lanes_t l);
    logic [SW-1:0] v;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        v[(x*5 + y)*64 +: 64] = l[x][y];
    return v;
  endfunction

  function automatic lanes_t unpack64(input logic [SW-1:0] v);
    lanes_t l;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        l[x][y] = v[(x*5 + y)*64 +: 64];
    return l;
  endfunction

  function automatic logic [199:0] pack8(input lanes_t l);
    logic [199:0] v;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        v[(x*5 + y)*8 +: 8] = l[x][y][7:0];
    return v;
  endfunction

  function automatic lanes_t unpack8(input logic [199:0] v);
    lanes_t l;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        l[x][y] = {56'd0, v[(x*5 + y)*8 +: 8]};
    return l;
  endfunction

  function automatic lanes_t rand_lanes(input int w);
    lanes_t l;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        if (w == 64) l[x][y] = {$urandom, $urandom};
        else         l[x][y] = 64'($urandom_range(0, 255));
    return l;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    int bad;
    logic found;
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      bad = 0;
      found = 1'b0;
      for (int i = 0; i < 25; i++)
        if (!found && (obs[i*64 +: 64] !== exp[i*64 +: 64])) begin
          bad = i;
          found = 1'b1;
        end
      $error("FAIL %s lane[%0d][%0d] obs=%0h exp=%0h", tag, bad / 5, bad % 5,
             obs[bad*64 +: 64], exp[bad*64 +: 64]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rd(input int d, output logic ir, output logic ov, output logic [SW-1:0] od,
                    output logic me, output int occ);
    if (d == 0) begin
      ir = a_in_ready; ov = a_out_valid; od = a_dout; me = a_mode_err; occ = int'(a_occ);
    end else begin
      ir = b_in_ready; ov = b_out_valid; od = pack64(unpack8(b_dout));
      me = b_mode_err; occ = int'(b_occ);
    end
  endtask

  // One clock of traffic on instance d. Entered and left at posedge+1.
  // exp_ov < 0 means out_valid is not predicted for this cycle.
  task automatic step(input int d, input logic v, input logic [1:0] m, input lanes_t l,
                      input logic ordy, input int exp_ov);
    logic ir, ov, me, acc, xfer, stalled, exp_ir;
    logic [SW-1:0] od, held, e;
    int occ_o, n;
    n = (d == 0) ? NA : NB;
    if (d == 0) begin
      a_in_valid = v; a_in_mode = m; a_din = pack64(l); a_out_ready = ordy;
    end else begin
      b_in_valid = v; b_in_mode = m; b_din = pack8(l); b_out_ready = ordy;
    end
    #1;
    rd(d, ir, ov, od, me, occ_o);
    exp_ir = !(occ_m[d] == n && !ordy);
    chk($sformatf("in_ready_%0d", d), ir, exp_ir);
    acc = v && exp_ir;
    if (d == 0) chk("out_valid_0", ov, occ_m[0] == 1);
    else if (exp_ov >= 0) chk("out_valid_1", ov, exp_ov[0]);
    xfer = ov && ordy;
    stalled = ov && !ordy;
    held = od;
    if (xfer) begin
      chk($sformatf("q_nonempty_%0d", d), (d == 0) ? exp_q_a.size() : exp_q_b.size(), 64'd0 + ((d == 0) ? (exp_q_a.size() > 0) : (exp_q_b.size() > 0)) * 0 + ((d == 0) ? exp_q_a.size() : exp_q_b.size()) + ((((d == 0) ? exp_q_a.size() : exp_q_b.size()) == 0) ? 1 : 0));
      if (d == 0 && exp_q_a.size() > 0) begin
        e = exp_q_a.pop_front();
        chk_state("data_0", od, e);
      end else if (d == 1 && exp_q_b.size() > 0) begin
        e = exp_q_b.pop_front();
        chk_state("data_1", od, e);
      end
      cap_q.push_back(od);
    end
    if (acc) begin
      if (d == 0) exp_q_a.push_back(pack64(ref_pi(l, m)));
      else        exp_q_b.push_back(pack64(ref_pi(l, m)));
    end
    occ_m[d] = occ_m[d] + (acc ? 1 : 0) - (xfer ? 1 : 0);
    @(posedge clk);
    #1;
    rd(d, ir, ov, od, me, occ_o);
    chk($sformatf("occupancy_%0d", d), occ_o, occ_m[d]);
    chk($sformatf("mode_err_%0d", d), me, acc && (m == 2'b11));
    if (stalled) begin
      chk($sformatf("stall_valid_%0d", d), ov, 1'b1);
      chk_state($sformatf("stall_data_%0d", d), od, held);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lanes_t zl, l;
    logic [SW-1:0] fwd_q [$];
    n_checks = 0;
    n_errors = 0;
    occ_m[0] = 0;
    occ_m[1] = 0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        zl[x][y] = '0;
    a_in_valid = 0; a_in_mode = 0; a_din = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_mode = 0; b_din = '0; b_out_ready = 0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov_a", a_out_valid, 1'b0);
    chk("rst_ov_b", b_out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ir_a", a_in_ready, 1'b1);
    chk("rst_ir_b", b_in_ready, 1'b1);
    chk("rst_occ_a", a_occ, 0);
    chk("rst_occ_b", b_occ, 0);
    chk("rst_me_a", a_mode_err, 1'b0);
    chk("rst_me_b", b_mode_err, 1'b0);
    chk_state("rst_data_a", a_dout, '0);
    chk_state("rst_data_b", pack64(unpack8(b_dout)), '0);

    // Forward pi on the hex-coordinate pattern
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        l[x][y] = 64'(x*16 + y);
    step(0, 1'b1, 2'b00, l, 1'b1, -1);
    chk("fwd_out10", a_dout[1][0], 64'h11);
    chk("fwd_out01", a_dout[0][1], 64'h30);
    step(0, 1'b0, 2'b00, zl, 1'b1, -1);

    // Reserved mode behaves as identity and flags once
    l = rand_lanes(64);
    step(0, 1'b1, 2'b11, l, 1'b1, -1);
    step(0, 1'b0, 2'b00, zl, 1'b1, -1);
    chk_state("rsvd_identity", a_dout, pack64(l));

    // Random traffic on the single-stage instance
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_lanes(64),
           $urandom_range(0, 3) != 0, -1);
    for (int i = 0; i < 10 && exp_q_a.size() > 0; i++)
      step(0, 1'b0, 2'b00, zl, 1'b1, -1);
    chk("drain_a", exp_q_a.size(), 0);

    // Three-stage latency
    step(1, 1'b1, 2'b00, rand_lanes(8), 1'b1, 0);
    step(1, 1'b0, 2'b00, zl, 1'b1, 0);
    step(1, 1'b0, 2'b00, zl, 1'b1, 0);
    step(1, 1'b0, 2'b00, zl, 1'b1, 1);

    // Backpressure: fill while output stalls, then release
    for (int i = 0; i < 5; i++)
      step(1, 1'b1, 2'($urandom_range(0, 2)), rand_lanes(8), 1'b0, -1);
    chk("bp_occ", b_occ, 3);
    chk("bp_ir", b_in_ready, 1'b0);
    cap_q.delete();
    for (int i = 0; i < 3; i++)
      step(1, 1'b0, 2'b00, zl, 1'b1, 1);
    chk("bp_count", cap_q.size(), 3);
    chk("bp_empty", exp_q_b.size(), 0);

    // Full pipe with both sides ready: pass-through, occupancy holds
    for (int i = 0; i < 3; i++)
      step(1, 1'b1, 2'b01, rand_lanes(8), 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b1, 2'($urandom_range(0, 3)), rand_lanes(8), 1'b1, 1);
      chk("full_occ", b_occ, 3);
    end
    for (int i = 0; i < 10 && exp_q_b.size() > 0; i++)
      step(1, 1'b0, 2'b00, zl, 1'b1, -1);

    // Reset with two states in flight
    step(1, 1'b1, 2'b00, rand_lanes(8), 1'b0, -1);
    step(1, 1'b1, 2'b00, rand_lanes(8), 1'b0, -1);
    chk("pre_rst_occ", b_occ, 2);
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", b_out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ov", b_out_valid, 1'b0);
    chk("post_rst_occ", b_occ, 0);
    chk("post_rst_ir", b_in_ready, 1'b1);
    chk_state("post_rst_data", pack64(unpack8(b_dout)), '0);
    exp_q_b.delete();
    occ_m[1] = 0;

    // Forward then inverse round trip over 1000 random states
    cap_q.delete();
    orig_q.delete();
    for (int i = 0; i < 1000; i++) begin
      l = rand_lanes(8);
      orig_q.push_back(pack64(l));
      step(1, 1'b1, 2'b00, l, 1'b1, -1);
    end
    for (int i = 0; i < 10 && exp_q_b.size() > 0; i++)
      step(1, 1'b0, 2'b00, zl, 1'b1, -1);
    chk("rt_fwd_count", cap_q.size(), 1000);
    fwd_q = cap_q;
    cap_q.delete();
    foreach (fwd_q[i])
      step(1, 1'b1, 2'b01, unpack64(fwd_q[i]), 1'b1, -1);
    for (int i = 0; i < 10 && exp_q_b.size() > 0; i++)
      step(1, 1'b0, 2'b00, zl, 1'b1, -1);
    chk("rt_inv_count", cap_q.size(), orig_q.size());
    for (int i = 0; i < cap_q.size() && i < orig_q.size(); i++)
      chk_state("roundtrip", cap_q[i], orig_q[i]);

    // Random traffic on the three-stage instance
    for (int i = 0; i < 400; i++)
      step(1, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_lanes(8),
           $urandom_range(0, 2) != 0, -1);
    for (int i = 0; i < 10 && exp_q_b.size() > 0; i++)
      step(1, 1'b0, 2'b00, zl, 1'b1, -1);
    chk("drain_b", exp_q_b.size(), 0);

    // Report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
